// File: rtl/serial_full_adder.sv
// -----------------------------------------------------------------------------
// serial_full_adder
//   Multi-cycle ripple adder/subtractor. One DIGIT-bit adder slice is reused
//   over WIDTH/DIGIT clocks, LSB digit first, with a registered carry between
//   digits. Subtraction is a + ~b + ~cin, so cout=1 means "no borrow".
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request, sampled only while idle
//   sub       0: a+b+cin   1: a-b-cin
//   a, b      WIDTH-bit operands, captured on the start edge
//   cin       carry-in / borrow-in, captured on the start edge
//   busy      high while an operation is running or completing
//   done      one-cycle pulse, result valid
//   sum       registered result (held until the next completion)
//   cout      carry-out (subtract: 1 = no borrow)
//   overflow  two's-complement overflow of the result
// -----------------------------------------------------------------------------
module serial_full_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
      $error("serial_full_adder: WIDTH must be >= 2 and an integer multiple of DIGIT");
   end

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [DIGIT:0]         dsum;
   logic                   c_msb;
   logic                   last;
   logic [WIDTH+DIGIT-1:0] res_cat;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   // Digit slice and next-state / datapath logic
   always_comb begin
      dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
      // Carry into the slice's top bit, recovered as a^b^s at that bit; on the
      // last digit this is the carry into bit WIDTH-1.
      c_msb   = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
      // New digit enters from the MSB end; works even when DIGIT == WIDTH.
      res_cat = {dsum[DIGIT-1:0], res_q};
      last    = (cnt_q == CW'(N - 1));

      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = cin ^ sub;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            res_d   = res_cat[WIDTH+DIGIT-1:DIGIT];
            carry_d = dsum[DIGIT];
            cnt_d   = cnt_q + CW'(1);
            if (last) begin
               sum_d   = res_cat[WIDTH+DIGIT-1:DIGIT];
               cout_d  = dsum[DIGIT];
               ovf_d   = c_msb ^ dsum[DIGIT];
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs, decoded from registers only
   always_comb begin
      busy     = (state_q != IDLE);
      done     = (state_q == DONE);
      sum      = sum_q;
      cout     = cout_q;
      overflow = ovf_q;
   end

endmodule

// File: tb/tb_serial_full_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_full_adder
//   Four instances (8/1, 8/2, 16/4, 32/8) share the operand buses and have
//   individual start lines. An arithmetic reference model predicts every
//   output every cycle; directed operations also pin literal results.
// -----------------------------------------------------------------------------
module tb_serial_full_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [3:0]  st;
   logic        sub, cin;
   logic [31:0] a_bus, b_bus;

   logic        bz0, bz1, bz2, bz3, dn0, dn1, dn2, dn3;
   logic        co0, co1, co2, co3, ov0, ov1, ov2, ov3;
   logic [7:0]  s0, s1;
   logic [15:0] s2;
   logic [31:0] s3;

   logic        bz[4], dn[4], co[4], ov[4];
   logic [31:0] sm[4];

   int errors = 0;
   int checks = 0;

   serial_full_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
      .clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sub), .a(a_bus[7:0]), .b(b_bus[7:0]),
      .cin(cin), .busy(bz0), .done(dn0), .sum(s0), .cout(co0), .overflow(ov0));
   serial_full_adder #(.WIDTH(8), .DIGIT(2)) u_w8d2 (
      .clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sub), .a(a_bus[7:0]), .b(b_bus[7:0]),
      .cin(cin), .busy(bz1), .done(dn1), .sum(s1), .cout(co1), .overflow(ov1));
   serial_full_adder #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
      .clk(clk), .rst_n(rst_n), .start(st[2]), .sub(sub), .a(a_bus[15:0]), .b(b_bus[15:0]),
      .cin(cin), .busy(bz2), .done(dn2), .sum(s2), .cout(co2), .overflow(ov2));
   serial_full_adder #(.WIDTH(32), .DIGIT(8)) u_w32d8 (
      .clk(clk), .rst_n(rst_n), .start(st[3]), .sub(sub), .a(a_bus), .b(b_bus),
      .cin(cin), .busy(bz3), .done(dn3), .sum(s3), .cout(co3), .overflow(ov3));

   always_comb begin
      bz[0] = bz0; bz[1] = bz1; bz[2] = bz2; bz[3] = bz3;
      dn[0] = dn0; dn[1] = dn1; dn[2] = dn2; dn[3] = dn3;
      co[0] = co0; co[1] = co1; co[2] = co2; co[3] = co3;
      ov[0] = ov0; ov[1] = ov1; ov[2] = ov2; ov[3] = ov3;
      sm[0] = {24'd0, s0}; sm[1] = {24'd0, s1}; sm[2] = {16'd0, s2}; sm[3] = s3;
   end

   function automatic int wof(input int i);
      case (i)
         0: return 8;
         1: return 8;
         2: return 16;
         default: return 32;
      endcase
   endfunction

   function automatic int nof(input int i);
      case (i)
         0: return 8;
         default: return 4;
      endcase
   endfunction

   // Reference arithmetic: plain integer add/subtract, unsigned for carry,
   // signed range test for overflow.
   function automatic void ref_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                                  input logic ci, input logic sb, output logic [31:0] s,
                                  output logic c, output logic o);
      longint one, m, ua, ub, sa, sbv, cl, r, sr;
      one = 1;
      m   = (one << w) - 1;
      cl  = ci ? one : 0;
      ua  = longint'(av) & m;
      ub  = longint'(bv) & m;
      sa  = (ua >= (one << (w - 1))) ? ua - (one << w) : ua;
      sbv = (ub >= (one << (w - 1))) ? ub - (one << w) : ub;
      if (!sb) begin
         r  = ua + ub + cl;
         c  = (r > m);
         sr = sa + sbv + cl;
      end else begin
         r  = ua - ub - cl;
         c  = (r >= 0);
         sr = sa - sbv - cl;
      end
      s = 32'(r & m);
      o = (sr >= (one << (w - 1))) || (sr < -(one << (w - 1)));
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[inst %0d]: got %0h, expected %0h", nm, idx, act, exp);
      end
   endtask

   // Cycle-level model: phase counts edges since the start edge
   // (0 = idle, N+1 = done cycle).
   int          ph[4];
   logic [31:0] ps[4], es[4];
   logic        pc[4], po[4], ec[4], eo[4];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            ph[i] = 0; es[i] = '0; ec[i] = 1'b0; eo[i] = 1'b0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (ph[i] == 0) begin
               if (st[i]) begin
                  ref_op(wof(i), a_bus, b_bus, cin, sub, ps[i], pc[i], po[i]);
                  ph[i] = 1;
               end
            end else if (ph[i] == nof(i) + 1) begin
               ph[i] = 0;
            end else begin
               ph[i]++;
               if (ph[i] == nof(i) + 1) begin
                  es[i] = ps[i]; ec[i] = pc[i]; eo[i] = po[i];
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 4; i++) begin
            chk("busy", i, 32'(bz[i]), 32'(ph[i] != 0));
            chk("done", i, 32'(dn[i]), 32'(ph[i] == nof(i) + 1));
            chk("sum", i, sm[i], es[i]);
            chk("cout", i, 32'(co[i]), 32'(ec[i]));
            chk("overflow", i, 32'(ov[i]), 32'(eo[i]));
         end
      end
   end

   // One operation on instance i. Samples 1 time unit after each edge;
   // e = edges since the start edge. Optional disturbance pulses start and
   // changes operands while the operation runs.
   task automatic run_op(input int i, input logic [31:0] av, input logic [31:0] bv,
                         input logic ci, input logic sb, input logic [31:0] xs,
                         input logic xc, input logic xo, input bit dis);
      int e, lat, dcnt, fall, n;
      n = nof(i);
      @(negedge clk);
      a_bus = av; b_bus = bv; cin = ci; sub = sb; st[i] = 1'b1;
      @(posedge clk); #1;
      st[i] = 1'b0;
      e = 0; lat = -1; dcnt = 0; fall = -1;
      while ((e < 80) && (fall < 0)) begin
         if (dn[i]) begin
            dcnt++;
            if (lat < 0) lat = e;
         end
         if (!bz[i]) fall = e;
         if (dis && ((e == 1) || (e == 2))) begin
            st[i] = 1'b1; a_bus = $urandom; b_bus = $urandom; cin = ~ci; sub = ~sb;
         end
         if (dis && (e == 3)) st[i] = 1'b0;
         if (fall < 0) begin
            @(posedge clk); #1;
            e++;
         end
      end
      chk("done_edge", i, 32'(lat), 32'(n));
      chk("busy_fall_edge", i, 32'(fall), 32'(n + 1));
      chk("done_pulses", i, 32'(dcnt), 32'd1);
      chk("op_sum", i, sm[i], xs);
      chk("op_cout", i, 32'(co[i]), 32'(xc));
      chk("op_overflow", i, 32'(ov[i]), 32'(xo));
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] av, bv, xs;
      logic        ci, sb, xc, xo;
      int          dcnt;

      rst_n = 1'b0; st = '0; sub = 1'b0; cin = 1'b0; a_bus = '0; b_bus = '0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk("rst_busy", i, 32'(bz[i]), 32'd0);
         chk("rst_done", i, 32'(dn[i]), 32'd0);
         chk("rst_sum", i, sm[i], 32'd0);
         chk("rst_cout", i, 32'(co[i]), 32'd0);
         chk("rst_overflow", i, 32'(ov[i]), 32'd0);
      end
      rst_n = 1'b1;

      run_op(0, 32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0);
      run_op(0, 32'h05, 32'h07, 1'b0, 1'b1, 32'hFE, 1'b0, 1'b0, 1'b0);
      run_op(0, 32'h80, 32'h01, 1'b0, 1'b1, 32'h7F, 1'b1, 1'b1, 1'b0);
      run_op(0, 32'h7F, 32'h00, 1'b1, 1'b0, 32'h80, 1'b0, 1'b1, 1'b0);
      run_op(2, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0, 1'b0);
      // 0x3C+0x55+1 = 0x92: no unsigned carry, signed 146 overflows
      run_op(0, 32'h3C, 32'h55, 1'b1, 1'b0, 32'h92, 1'b0, 1'b1, 1'b1);

      // start held high: one result every N+2 clocks (N=4 -> 3 in 18 edges)
      @(negedge clk);
      st[1] = 1'b1; a_bus = $urandom; b_bus = $urandom;
      dcnt = 0;
      for (int c = 0; c < 18; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (dn[1]) dcnt++;
         a_bus = $urandom; b_bus = $urandom;
         cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      end
      st[1] = 1'b0;
      chk("held_done_pulses", 1, 32'(dcnt), 32'd3);
      repeat (8) @(negedge clk);

      // asynchronous reset in the middle of an operation
      @(negedge clk);
      a_bus = 32'hAA; b_bus = 32'h11; cin = 1'b0; sub = 1'b0; st[0] = 1'b1;
      @(posedge clk); #1;
      st[0] = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", 0, 32'(bz[0]), 32'd0);
      chk("midrst_done", 0, 32'(dn[0]), 32'd0);
      chk("midrst_sum", 0, sm[0], 32'd0);
      chk("midrst_cout", 0, 32'(co[0]), 32'd0);
      chk("midrst_overflow", 0, 32'(ov[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(0, 32'h12, 32'h34, 1'b0, 1'b0, 32'h46, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 250; k++) begin
            av = $urandom; bv = $urandom;
            ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
            ref_op(wof(i), av, bv, ci, sb, xs, xc, xo);
            run_op(i, av, bv, ci, sb, xs, xc, xo, 1'b0);
         end
      end

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
